// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/status block for an asynchronous FIFO: binary and Gray write
// pointers, memory write strobe/address, and registered full/almost-full/level/overflow.
module wptr_full_ctrl #(
    parameter int ADDR_SIZE    = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   rptr_sync,
    output logic                 wr_en,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 woverflow
);

    localparam logic [ADDR_SIZE:0] LP_AFULL = (ADDR_SIZE+1)'(AFULL_THRESH);

    logic [ADDR_SIZE:0] r_wbin;
    logic [ADDR_SIZE:0] r_wptr;
    logic               r_wfull;
    logic               r_walmost_full;
    logic [ADDR_SIZE:0] r_wlevel;
    logic               r_woverflow;

    logic [ADDR_SIZE:0] w_wbin_next;
    logic [ADDR_SIZE:0] w_wgray_next;
    logic [ADDR_SIZE:0] w_rbin;
    logic [ADDR_SIZE:0] w_level_next;
    logic [ADDR_SIZE:0] w_full_ptr;

    assign wr_en        = winc & ~r_wfull;
    assign w_wbin_next  = r_wbin + {{ADDR_SIZE{1'b0}}, wr_en};
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
    assign w_full_ptr   = {~rptr_sync[ADDR_SIZE:ADDR_SIZE-1], rptr_sync[ADDR_SIZE-2:0]};

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin = '0;
        for (int unsigned i = 0; i <= ADDR_SIZE; i++) begin
            w_rbin[i] = ^(rptr_sync >> i);
        end
    end

    assign w_level_next = w_wbin_next - w_rbin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= '0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= w_wgray_next;
            r_wfull        <= (w_wgray_next == w_full_ptr);
            r_walmost_full <= (w_level_next >= LP_AFULL);
            r_wlevel       <= w_level_next;
            r_woverflow    <= winc & r_wfull;
        end
    end

    assign waddr        = r_wbin[ADDR_SIZE-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;
    assign woverflow    = r_woverflow;

endmodule
